// File: rtl/hack_kbd_ps2_rx_pkg.sv
// Shared constants for the Hack keyboard receiver.
// Contents: bus widths, Hack key codes, the PS/2 set-2 prefix bytes,
// the frame-state enum, and an ASCII-to-key-code helper.
package hack_kbd_pkg;

  localparam int unsigned KEY_W  = 16;
  localparam int unsigned SCAN_W = 8;

  localparam logic [KEY_W-1:0] KEY_NONE      = 16'd0;
  localparam logic [KEY_W-1:0] KEY_SPACE     = 16'd32;
  localparam logic [KEY_W-1:0] KEY_NEWLINE   = 16'd128;
  localparam logic [KEY_W-1:0] KEY_BACKSPACE = 16'd129;
  localparam logic [KEY_W-1:0] KEY_LEFT      = 16'd130;
  localparam logic [KEY_W-1:0] KEY_UP        = 16'd131;
  localparam logic [KEY_W-1:0] KEY_RIGHT     = 16'd132;
  localparam logic [KEY_W-1:0] KEY_DOWN      = 16'd133;
  localparam logic [KEY_W-1:0] KEY_HOME      = 16'd134;
  localparam logic [KEY_W-1:0] KEY_END       = 16'd135;
  localparam logic [KEY_W-1:0] KEY_PGUP      = 16'd136;
  localparam logic [KEY_W-1:0] KEY_PGDN      = 16'd137;
  localparam logic [KEY_W-1:0] KEY_INSERT    = 16'd138;
  localparam logic [KEY_W-1:0] KEY_DELETE    = 16'd139;
  localparam logic [KEY_W-1:0] KEY_ESC       = 16'd140;
  localparam logic [KEY_W-1:0] KEY_F1        = 16'd141;
  localparam logic [KEY_W-1:0] KEY_F12       = 16'd152;

  localparam logic [SCAN_W-1:0] PS2_EXT = 8'hE0;
  localparam logic [SCAN_W-1:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  // Printable keys map straight to their ASCII value.
  function automatic logic [KEY_W-1:0] key_ascii(input logic [7:0] c);
    return {8'h00, c};
  endfunction

endpackage

// File: rtl/hack_kbd_ps2_rx_if.sv
// Keyboard receiver bus: raw PS/2 lines in, Hack key word and scan strobes out.
// master = line driver / reader of results, slave = the receiver.
//   ps2_clk, ps2_data : PS/2 lines (idle high)
//   key               : Hack key code of the held key, 0 = none
//   scan_valid        : one-cycle pulse per good byte
//   scan_code         : last good byte
//   frame_err         : one-cycle pulse on a bad or abandoned frame
interface hack_kbd_ps2_rx_if;
  import hack_kbd_pkg::*;

  logic              ps2_clk;
  logic              ps2_data;
  logic [KEY_W-1:0]  key;
  logic              scan_valid;
  logic [SCAN_W-1:0] scan_code;
  logic              frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  key, scan_valid, scan_code, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key, scan_valid, scan_code, frame_err
  );
endinterface

// File: rtl/hack_kbd_ps2_rx_map.sv
// Combinational PS/2 scan-code set 2 to Hack key-code lookup.
// Ports: i_ext (byte was preceded by E0), i_byte (scan byte),
//        o_code_c (Hack key code, 0 when the key has no Hack code).
module ps2_set2_to_hack
  import hack_kbd_pkg::*;
(
  input  logic              i_ext,
  input  logic [SCAN_W-1:0] i_byte,
  output logic [KEY_W-1:0]  o_code_c
);

  always_comb begin
    o_code_c = KEY_NONE;
    if (i_ext) begin
      case (i_byte)
        8'h6B:   o_code_c = KEY_LEFT;
        8'h75:   o_code_c = KEY_UP;
        8'h74:   o_code_c = KEY_RIGHT;
        8'h72:   o_code_c = KEY_DOWN;
        8'h6C:   o_code_c = KEY_HOME;
        8'h69:   o_code_c = KEY_END;
        8'h7D:   o_code_c = KEY_PGUP;
        8'h7A:   o_code_c = KEY_PGDN;
        8'h70:   o_code_c = KEY_INSERT;
        8'h71:   o_code_c = KEY_DELETE;
        default: o_code_c = KEY_NONE;
      endcase
    end else begin
      case (i_byte)
        8'h1C: o_code_c = key_ascii("A");
        8'h32: o_code_c = key_ascii("B");
        8'h21: o_code_c = key_ascii("C");
        8'h23: o_code_c = key_ascii("D");
        8'h24: o_code_c = key_ascii("E");
        8'h2B: o_code_c = key_ascii("F");
        8'h34: o_code_c = key_ascii("G");
        8'h33: o_code_c = key_ascii("H");
        8'h43: o_code_c = key_ascii("I");
        8'h3B: o_code_c = key_ascii("J");
        8'h42: o_code_c = key_ascii("K");
        8'h4B: o_code_c = key_ascii("L");
        8'h3A: o_code_c = key_ascii("M");
        8'h31: o_code_c = key_ascii("N");
        8'h44: o_code_c = key_ascii("O");
        8'h4D: o_code_c = key_ascii("P");
        8'h15: o_code_c = key_ascii("Q");
        8'h2D: o_code_c = key_ascii("R");
        8'h1B: o_code_c = key_ascii("S");
        8'h2C: o_code_c = key_ascii("T");
        8'h3C: o_code_c = key_ascii("U");
        8'h2A: o_code_c = key_ascii("V");
        8'h1D: o_code_c = key_ascii("W");
        8'h22: o_code_c = key_ascii("X");
        8'h35: o_code_c = key_ascii("Y");
        8'h1A: o_code_c = key_ascii("Z");
        8'h45: o_code_c = key_ascii("0");
        8'h16: o_code_c = key_ascii("1");
        8'h1E: o_code_c = key_ascii("2");
        8'h26: o_code_c = key_ascii("3");
        8'h25: o_code_c = key_ascii("4");
        8'h2E: o_code_c = key_ascii("5");
        8'h36: o_code_c = key_ascii("6");
        8'h3D: o_code_c = key_ascii("7");
        8'h3E: o_code_c = key_ascii("8");
        8'h46: o_code_c = key_ascii("9");
        8'h29: o_code_c = KEY_SPACE;
        8'h5A: o_code_c = KEY_NEWLINE;
        8'h66: o_code_c = KEY_BACKSPACE;
        8'h76: o_code_c = KEY_ESC;
        8'h05: o_code_c = KEY_F1;
        8'h06: o_code_c = KEY_F1 + 16'd1;
        8'h04: o_code_c = KEY_F1 + 16'd2;
        8'h0C: o_code_c = KEY_F1 + 16'd3;
        8'h03: o_code_c = KEY_F1 + 16'd4;
        8'h0B: o_code_c = KEY_F1 + 16'd5;
        8'h83: o_code_c = KEY_F1 + 16'd6;
        8'h0A: o_code_c = KEY_F1 + 16'd7;
        8'h01: o_code_c = KEY_F1 + 16'd8;
        8'h09: o_code_c = KEY_F1 + 16'd9;
        8'h78: o_code_c = KEY_F1 + 16'd10;
        8'h07: o_code_c = KEY_F12;
        default: o_code_c = KEY_NONE;
      endcase
    end
  end

endmodule

// File: rtl/hack_kbd_ps2_rx.sv
// PS/2 keyboard receiver feeding the Hack KBD word.
// Ports: clk, reset (async, active-high), bus (slave side of hack_kbd_ps2_rx_if):
//   ps2_clk/ps2_data in; key, scan_valid, scan_code, frame_err out (all registered).
module hack_kbd_ps2_rx
  import hack_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            reset,
  hack_kbd_ps2_rx_if.slave bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   r_fall;
  logic                   w_clk_s;
  logic                   w_data_s;

  frame_state_e           r_state;
  logic [2:0]             r_bit_cnt;
  logic [SCAN_W-1:0]      r_shift;
  logic                   r_parity;
  logic [TO_W-1:0]        r_to_cnt;
  logic                   r_scan_valid;
  logic [SCAN_W-1:0]      r_scan_code;
  logic                   r_frame_err;

  logic [KEY_W-1:0]       r_key;
  logic                   r_brk_pend;
  logic                   r_ext_pend;
  logic [KEY_W-1:0]       w_code;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Line synchronisers, preset high to match idle lines; fall strobe one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2_data};
      r_clk_prev  <= w_clk_s;
      r_fall      <= r_clk_prev & ~w_clk_s;
    end
  end

  // Frame FSM with inactivity timeout; a fall in the same cycle beats the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_scan_valid <= 1'b0;
      r_scan_code  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          ST_IDLE: begin
            if (!w_data_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_data_s, r_shift[SCAN_W-1:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            // Odd parity: data bits plus parity bit must XOR to 1.
            if (w_data_s && (^{r_shift, r_parity})) begin
              r_scan_valid <= 1'b1;
              r_scan_code  <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_state != ST_IDLE) begin
        if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          r_state     <= ST_IDLE;
          r_frame_err <= 1'b1;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  ps2_set2_to_hack u_map (
    .i_ext    (r_ext_pend),
    .i_byte   (r_scan_code),
    .o_code_c (w_code)
  );

  // Make/break decoder: tracks the single held key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key      <= KEY_NONE;
      r_brk_pend <= 1'b0;
      r_ext_pend <= 1'b0;
    end else if (r_scan_valid) begin
      if (r_scan_code == PS2_BRK) begin
        r_brk_pend <= 1'b1;
      end else if (r_scan_code == PS2_EXT) begin
        r_ext_pend <= 1'b1;
      end else begin
        if (!r_brk_pend && (w_code != KEY_NONE)) begin
          r_key <= w_code;
        end else if (r_brk_pend && (w_code == r_key)) begin
          r_key <= KEY_NONE;
        end
        r_brk_pend <= 1'b0;
        r_ext_pend <= 1'b0;
      end
    end
  end

  assign bus.key        = r_key;
  assign bus.scan_valid = r_scan_valid;
  assign bus.scan_code  = r_scan_code;
  assign bus.frame_err  = r_frame_err;

endmodule
